// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx fetch stage: FSM state encoding and reset constants.
package ysyx_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } ifu_state_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding word read at a
// time, holds the returned instruction for decode and squashes wrong-path fetches
// when execute redirects.
module ysyx_ifu
  import ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC,
  parameter logic [31:0] NOP_INST_P = NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  ifu_state_t  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;

  // Next-state logic; a redirect overrides every normal transition.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        // An accepted request in the redirect cycle still gets a response; drop it.
        FETCH: state_d = imem_req_ready ? DROP : FETCH;
        WAIT:  state_d = imem_rsp_valid ? FETCH : DROP;
        HOLD: begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST_P;
          state_d      = FETCH;
        end
        DROP:  state_d = imem_rsp_valid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: if (imem_req_ready) state_d = WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            inst_d       = imem_rsp_data;
            pc_d         = fetch_pc_q;
            inst_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;  // wraps 0xFFFF_FFFC -> 0
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST_P;
            state_d      = FETCH;
          end
        end
        DROP: if (imem_rsp_valid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC_P;
      inst_q       <= NOP_INST_P;
      pc_q         <= RESET_PC_P;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Request is masked during reset so memory never sees a fetch while rst is high.
  always_comb begin
    imem_req_valid = (state_q == FETCH) && !rst;
    imem_req_addr  = fetch_pc_q;
    inst_valid     = inst_valid_q;
    inst           = inst_q;
    pc             = pc_q;
  end

  // A response with nothing outstanding is a memory-side protocol violation.
  rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (state_q == FETCH || state_q == HOLD))
  );

endmodule

// File: tb/tb_ysyx_ifu.sv
// Directed bench for ysyx_ifu: reset, fetch/hold handshake, redirect squashing,
// request stability under back-pressure, PC wrap and mid-flight reset.
module tb_ysyx_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;

  int n_checks = 0;
  int n_errors = 0;
  int n_accepts = 0;
  int acc_before;

  always #5 clk = ~clk;

  ysyx_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc)
  );

  // Count request handshakes seen by memory.
  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) n_accepts++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_addr", imem_req_addr, 32'h8000_0000);

    // 1: first fetch after reset
    rst = 1'b0; imem_req_ready = 1'b1;
    #1;
    check("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t1_req_addr", imem_req_addr, 32'h8000_0000);
    tick();  // accepted -> WAIT
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    check("t1_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("t1_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();  // response -> HOLD
    imem_rsp_valid = 1'b0;
    check("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("t1_inst", inst, 32'h0010_0093);
    check("t1_pc", pc, 32'h8000_0000);
    check("t1_next_addr", imem_req_addr, 32'h8000_0004);

    // 2: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_inst_c%0d", i), inst, 32'h0010_0093);
      check($sformatf("t2_pc_c%0d", i), pc, 32'h8000_0000);
      check($sformatf("t2_req_valid_c%0d", i), {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();  // consumed -> FETCH
    inst_ready = 1'b0;
    check("t2_inst_valid_after", {31'd0, inst_valid}, 32'd0);
    check("t2_inst_nop", inst, 32'h0000_0013);
    check("t2_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t2_req_addr", imem_req_addr, 32'h8000_0004);

    // 3: redirect while waiting; late response discarded
    imem_req_ready = 1'b1;
    tick();  // WAIT
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();  // DROP
    redirect_valid = 1'b0;
    check("t3_drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("t3_drop_addr", imem_req_addr, 32'h8000_0100);
    tick();  // still DROP
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    check("t3_inst_valid_mid", {31'd0, inst_valid}, 32'd0);
    tick();  // discarded -> FETCH
    imem_rsp_valid = 1'b0;
    check("t3_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("t3_inst_nop", inst, 32'h0000_0013);
    check("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t3_req_addr", imem_req_addr, 32'h8000_0100);

    // 4: redirect in HOLD together with inst_ready
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113;
    tick();
    imem_rsp_valid = 1'b0;
    check("t4_inst", inst, 32'h0020_0113);
    check("t4_pc", pc, 32'h8000_0100);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    check("t4_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("t4_inst_nop", inst, 32'h0000_0013);
    check("t4_req_addr", imem_req_addr, 32'h8000_0200);

    // 5: memory back-pressure with a redirect in cycle 2
    acc_before = n_accepts;
    check("t5_c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t5_c1_addr", imem_req_addr, 32'h8000_0200);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    check("t5_c2_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();
    redirect_valid = 1'b0;
    check("t5_c3_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t5_c3_addr", imem_req_addr, 32'h8000_0300);
    tick();
    check("t5_c4_addr", imem_req_addr, 32'h8000_0300);
    imem_req_ready = 1'b1;
    tick();  // WAIT
    imem_req_ready = 1'b0;
    check("t5_req_valid_after", {31'd0, imem_req_valid}, 32'd0);
    check("t5_one_request", n_accepts - acc_before, 32'd1);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0030_0193;
    tick();  // HOLD
    imem_rsp_valid = 1'b0;
    check("t5_pc", pc, 32'h8000_0300);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // 6: PC wrap, then reset while a request is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    check("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    check("t6_top_pc", pc, 32'hFFFF_FFFC);
    check("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; imem_req_ready = 1'b1;
    check("t6_wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();  // WAIT
    imem_req_ready = 1'b0; rst = 1'b1;
    tick();
    check("t6_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("t6_rst_addr", imem_req_addr, 32'h8000_0000);
    check("t6_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("t6_post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
